// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, latches fetched instruction for decode,
// honours hazard-unit stall/PCWrite and branch flush, and keeps saturating debug counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             PCWrite_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      IFID_pc_o,
  output logic [31:0]      IFID_instr_o,
  output logic             IFID_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_eff;

  assign stall_eff = stall_i | ~PCWrite_i;

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (start_i) begin
      if (stall_eff) begin
        // Stall beats flush: the branch compare in ID used a stale operand.
        if (!stall_i) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = instr_i;
          ifid_valid_d = 1'b1;
        end
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CntOne;
      end else if (flush_i) begin
        pc_d         = branch_target_i;
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CntOne;
      end else begin
        pc_d         = pc_q + 32'd4;
        ifid_pc_d    = pc_q;
        ifid_instr_d = instr_i;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign IFID_pc_o    = ifid_pc_q;
  assign IFID_instr_o = ifid_instr_q;
  assign IFID_valid_o = ifid_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vectors, a per-cycle reference model compare on two instances
// (default counter width and a 4-bit one for saturation), plus hand-computed literal checks.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pcw = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'h0;

  logic [31:0] instr, pc, ipc, iins;
  logic        ival;
  logic [15:0] scnt, fcnt;
  logic [31:0] instr_s, pc_s, ipc_s, iins_s;
  logic        ival_s;
  logic [3:0]  scnt_s, fcnt_s;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents: word at address a reads a + 0x1000_0000.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign instr   = mem(pc);
  assign instr_s = mem(pc_s);

  if_id_stage u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .stall_i(stall),
    .flush_i(flush), .branch_target_i(target), .instr_i(instr), .pc_o(pc),
    .IFID_pc_o(ipc), .IFID_instr_o(iins), .IFID_valid_o(ival),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  if_id_stage #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .stall_i(stall),
    .flush_i(flush), .branch_target_i(target), .instr_i(instr_s), .pc_o(pc_s),
    .IFID_pc_o(ipc_s), .IFID_instr_o(iins_s), .IFID_valid_o(ival_s),
    .stall_cnt_o(scnt_s), .flush_cnt_o(fcnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded event counts, saturation applied when comparing.
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        m_v;
  int          m_sc, m_fc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 32'h0; m_ipc <= 32'h0; m_ins <= 32'h13; m_v <= 1'b0; m_sc <= 0; m_fc <= 0;
    end else if (start) begin
      if (stall || !pcw) begin
        m_sc <= m_sc + 1;
        if (!stall) begin
          m_ipc <= m_pc; m_ins <= mem(m_pc); m_v <= 1'b1;
        end
      end else if (flush) begin
        m_pc <= target; m_ipc <= 32'h0; m_ins <= 32'h13; m_v <= 1'b0; m_fc <= m_fc + 1;
      end else begin
        m_pc <= m_pc + 32'd4; m_ipc <= m_pc; m_ins <= mem(m_pc); m_v <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("ifid_pc", ipc, m_ipc);
      chk("ifid_instr", iins, m_ins);
      chk("ifid_valid", {31'h0, ival}, {31'h0, m_v});
      chk("stall_cnt", {16'h0, scnt}, sat(m_sc, 16'hFFFF));
      chk("flush_cnt", {16'h0, fcnt}, sat(m_fc, 16'hFFFF));
      chk("sat_pc", pc_s, m_pc);
      chk("sat_stall_cnt", {28'h0, scnt_s}, sat(m_sc, 15));
      chk("sat_flush_cnt", {28'h0, fcnt_s}, sat(m_fc, 15));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string name, input logic [31:0] p, input logic [31:0] i,
                      input logic v);
    chk({name, "_pc"}, ipc, p);
    chk({name, "_instr"}, iins, i);
    chk({name, "_valid"}, {31'h0, ival}, {31'h0, v});
  endtask

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_pc", pc, 32'h0);
    ifid("rst_ifid", 32'h0, 32'h0000_0013, 1'b0);
    chk("rst_scnt", {16'h0, scnt}, 32'h0);
    chk("rst_fcnt", {16'h0, fcnt}, 32'h0);

    rst = 1'b1; start = 1'b1;
    tick();
    chk("run1_pc", pc, 32'h4);
    ifid("run1", 32'h0, 32'h1000_0000, 1'b1);
    tick();
    chk("run2_pc", pc, 32'h8);
    ifid("run2", 32'h4, 32'h1000_0004, 1'b1);

    stall = 1'b1; pcw = 1'b0;
    tick();
    chk("lu_pc", pc, 32'h8);
    ifid("lu", 32'h4, 32'h1000_0004, 1'b1);
    chk("lu_scnt", {16'h0, scnt}, 32'h1);
    stall = 1'b0; pcw = 1'b1;
    tick();
    chk("resume_pc", pc, 32'hC);
    ifid("resume", 32'h8, 32'h1000_0008, 1'b1);

    flush = 1'b1; target = 32'h40;
    tick();
    chk("flush_pc", pc, 32'h40);
    ifid("flush", 32'h0, 32'h0000_0013, 1'b0);
    chk("flush_fcnt", {16'h0, fcnt}, 32'h1);
    flush = 1'b0;
    tick();
    chk("tgt_pc", pc, 32'h44);
    ifid("tgt", 32'h40, 32'h1000_0040, 1'b1);

    stall = 1'b1; pcw = 1'b0; flush = 1'b1; target = 32'h80;
    tick();
    chk("sf_pc", pc, 32'h44);
    ifid("sf", 32'h40, 32'h1000_0040, 1'b1);
    chk("sf_scnt", {16'h0, scnt}, 32'h2);
    chk("sf_fcnt", {16'h0, fcnt}, 32'h1);

    stall = 1'b0; flush = 1'b0;
    tick();
    chk("pcw_pc", pc, 32'h44);
    ifid("pcw", 32'h44, 32'h1000_0044, 1'b1);
    chk("pcw_scnt", {16'h0, scnt}, 32'h3);

    start = 1'b0; pcw = 1'b1; flush = 1'b1; target = 32'h200;
    tick();
    chk("idle_pc", pc, 32'h44);
    chk("idle_fcnt", {16'h0, fcnt}, 32'h1);

    start = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    chk("wrapf_pc", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("wrap_pc", pc, 32'h0);
    ifid("wrap", 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1);

    flush = 1'b1; target = 32'h102;
    tick();
    chk("odd_pc", pc, 32'h102);
    flush = 1'b0;
    tick();
    chk("odd_next_pc", pc, 32'h106);

    stall = 1'b1; pcw = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_scnt", {28'h0, scnt_s}, 32'hF);
    chk("wide_scnt", {16'h0, scnt}, 32'd23);
    chk("sat_fcnt", {28'h0, fcnt_s}, 32'h3);

    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    ifid("arst", 32'h0, 32'h0000_0013, 1'b0);
    chk("arst_scnt", {16'h0, scnt}, 32'h0);
    chk("arst_fcnt", {16'h0, fcnt}, 32'h0);
    chk("arst_sat_scnt", {28'h0, scnt_s}, 32'h0);

    tick();
    rst = 1'b1; stall = 1'b0; pcw = 1'b1;
    tick();
    chk("rel_pc", pc, 32'h4);
    tick();
    tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
